// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one {1'b1, addr[6:0], data} frame per accepted request.
// Optional macro SPI_CTRL_ADDR_CHECK_EN rejects addresses above MAX_ADDR without sending a frame.
module spi_controller #(
  parameter int W          = 8,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_ADDR   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [6:0]   req_addr,
  input  logic [W-1:0] req_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         sclk,
  output logic         ncs,
  output logic         copi
);

  localparam int FRAME = 8 + W;
  localparam int BW    = $clog2(FRAME);
  localparam int MAXC  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW    = $clog2(MAXC);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    div_cnt, div_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [FRAME-1:0] shreg, shreg_nxt;
  logic             sclk_nxt, ncs_nxt, copi_nxt, done_nxt, err_nxt, busy_nxt, ready_nxt;
  logic             handshake, div_last, gap_last, addr_bad;

  assign handshake = req_valid & req_ready;
  assign div_last  = (div_cnt == CW'(CLK_DIV - 1));
  assign gap_last  = (div_cnt == CW'(GAP_CYCLES - 1));

`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign addr_bad = (req_addr > 7'(MAX_ADDR));
`else
  assign addr_bad = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt + CW'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk;
    ncs_nxt   = ncs;
    copi_nxt  = copi;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = {CW{1'b0}};
        if (handshake) begin
          if (addr_bad) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            shreg_nxt = {1'b1, req_addr, req_data};
            bit_nxt   = BW'(FRAME - 1);
            ncs_nxt   = 1'b0;
            copi_nxt  = 1'b1;
            state_nxt = SETUP;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP, LOW: begin
        if (div_last) begin
          div_nxt   = {CW{1'b0}};
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end else begin
          state_nxt = state;
        end
      end
      HIGH: begin
        if (div_last) begin
          div_nxt  = {CW{1'b0}};
          sclk_nxt = 1'b0;
          if (bit_cnt == {BW{1'b0}}) begin
            state_nxt = TAIL;
          end else begin
            // copi only moves together with the falling sclk edge
            copi_nxt  = shreg[FRAME-2];
            shreg_nxt = {shreg[FRAME-2:0], 1'b0};
            bit_nxt   = bit_cnt - BW'(1);
            state_nxt = LOW;
          end
        end else begin
          state_nxt = HIGH;
        end
      end
      TAIL: begin
        if (div_last) begin
          div_nxt   = {CW{1'b0}};
          ncs_nxt   = 1'b1;
          copi_nxt  = 1'b0;
          state_nxt = GAP;
        end else begin
          state_nxt = TAIL;
        end
      end
      GAP: begin
        if (gap_last) begin
          div_nxt   = {CW{1'b0}};
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        div_nxt   = {CW{1'b0}};
        sclk_nxt  = 1'b0;
        ncs_nxt   = 1'b1;
        copi_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= {CW{1'b0}};
      bit_cnt   <= {BW{1'b0}};
      shreg     <= {FRAME{1'b0}};
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      sclk      <= sclk_nxt;
      ncs       <= ncs_nxt;
      copi      <= copi_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      req_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed self-checking bench for spi_controller (default C=4 instance plus a C=6 instance).
// A behavioural SPI peripheral model decodes frames sampled on sclk rising edges.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, busy, done, err, sclk, ncs, copi;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       req_valid_b, req_ready_b, busy_b, done_b, err_b, sclk_b, ncs_b, copi_b;
  logic [6:0] req_addr_b;
  logic [7:0] req_data_b;

  spi_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .err(err), .sclk(sclk), .ncs(ncs), .copi(copi)
  );

  spi_controller #(.CLK_DIV(6)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_data(req_data_b), .busy(busy_b), .done(done_b),
    .err(err_b), .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b)
  );

  int checks = 0;
  int errors = 0;

  // Peripheral model on the default instance
  logic [7:0]  pregs [0:4];
  logic [15:0] sh = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  int          rises = 0, last_rises = 0, frames = 0, idle_viol = 0, err_seen = 0;
  int          hicnt = 0, last_gap = 0;
  logic        prev_sclk = 1'b0, prev_ncs = 1'b1;

  always @(negedge clk) begin
    if (ncs === 1'b1 && sclk === 1'b1) idle_viol++;
    if (err === 1'b1) err_seen++;
    if (ncs === 1'b0 && prev_ncs === 1'b1) begin
      rises    = 0;
      last_gap = hicnt;
    end
    if (ncs === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
      sh = {sh[14:0], copi};
      rises++;
    end
    if (ncs === 1'b1 && prev_ncs === 1'b0) begin
      frames++;
      last_frame = sh;
      last_rises = rises;
      if (rises == 16 && sh[15] && sh[14:8] <= 7'd4) pregs[sh[10:8]] = sh[7:0];
    end
    hicnt     = (ncs === 1'b1) ? hicnt + 1 : 0;
    prev_sclk = sclk;
    prev_ncs  = ncs;
  end

  task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                          output int done_cyc, output int ncs_first, output int ncs_last,
                          output logic rdy1, output logic busy1);
    done_cyc = -1; ncs_first = -1; ncs_last = -1; rdy1 = 1'bx; busy1 = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; rdy1 = req_ready; busy1 = busy;
      end
      if (ncs === 1'b0) begin
        if (ncs_first < 0) ncs_first = k;
        ncs_last = k;
      end
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 7'd0; req_data = 8'd0;
    req_valid_b = 1'b0; req_addr_b = 7'd0; req_data_b = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ncs, sclk, copi, done, err, busy, req_ready} !== 7'b1000001) begin
      errors++;
      $display("FAIL reset_a: got %b expected 1000001", {ncs, sclk, copi, done, err, busy, req_ready});
    end
    checks++;
    if ({ncs_b, sclk_b, copi_b, done_b, err_b, busy_b, req_ready_b} !== 7'b1000001) begin
      errors++;
      $display("FAIL reset_b: got %b expected 1000001", {ncs_b, sclk_b, copi_b, done_b, err_b, busy_b, req_ready_b});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int dc, nf, nl;
    logic r1, b1;
    do_write(7'h00, 8'hF0, dc, nf, nl, r1, b1);
    checks++;
    if (dc !== 141) begin errors++; $display("FAIL single_done_cycle: got %0d expected 141", dc); end
    checks++;
    if (nf !== 1 || nl !== 132) begin errors++; $display("FAIL single_ncs_window: got %0d..%0d expected 1..132", nf, nl); end
    checks++;
    if (r1 !== 1'b0 || b1 !== 1'b1) begin errors++; $display("FAIL single_ready_busy_c1: got ready=%b busy=%b expected 0 1", r1, b1); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready_at_done: got %b expected 1", req_ready); end
    checks++;
    if (last_frame !== 16'h80F0) begin errors++; $display("FAIL single_frame: got %h expected 80f0", last_frame); end
    checks++;
    if (last_rises !== 16) begin errors++; $display("FAIL single_rises: got %0d expected 16", last_rises); end
    checks++;
    if (pregs[0] !== 8'hF0) begin errors++; $display("FAIL single_reg0: got %h expected f0", pregs[0]); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    int dc1 = -1, dc2 = -1, f0;
    logic rdy_at_done = 1'b0;
    f0 = frames;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h01; req_data = 8'hAA;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin req_addr = 7'h04; req_data = 8'h55; end
      if (done === 1'b1) begin dc1 = k; rdy_at_done = req_ready; break; end
    end
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (done === 1'b1) begin dc2 = k; break; end
    end
    checks++;
    if (dc1 !== 141 || dc2 !== 141) begin errors++; $display("FAIL b2b_done_cycles: got %0d %0d expected 141 141", dc1, dc2); end
    checks++;
    if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %b expected 1", rdy_at_done); end
    checks++;
    if (frames - f0 !== 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", frames - f0); end
    checks++;
    if (pregs[1] !== 8'hAA || pregs[4] !== 8'h55) begin errors++; $display("FAIL b2b_regs: got %h %h expected aa 55", pregs[1], pregs[4]); end
    checks++;
    if (last_gap !== 9) begin errors++; $display("FAIL b2b_ncs_gap: got %0d expected 9", last_gap); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    logic copi50 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h03; req_data = 8'hFF;
    @(posedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 50) begin copi50 = copi; rst = 1'b1; end
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (copi50 !== 1'b1) begin errors++; $display("FAIL rstmid_copi_before: got %b expected 1", copi50); end
    checks++;
    if ({ncs, sclk, copi, done, err, busy, req_ready} !== 7'b1000001) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b expected 1000001", {ncs, sclk, copi, done, err, busy, req_ready});
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    checks++;
    if (pregs[3] !== 8'h00) begin errors++; $display("FAIL rstmid_reg3: got %h expected 00", pregs[3]); end
  endtask

  task automatic test_valid_while_busy();
    int dc = -1, f0, v0;
    f0 = frames; v0 = idle_viol;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h02; req_data = 8'h5A;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      req_valid = (k < 130) ? k[0] : 1'b0;
      req_addr  = 7'h03; req_data = 8'h11;
      if (done === 1'b1) begin dc = k; break; end
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (dc !== 141) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 141", dc); end
    checks++;
    if (frames - f0 !== 1) begin errors++; $display("FAIL busy_frames: got %0d expected 1", frames - f0); end
    checks++;
    if (last_frame !== 16'h825A || last_rises !== 16) begin
      errors++; $display("FAIL busy_frame: got %h rises %0d expected 825a rises 16", last_frame, last_rises);
    end
    checks++;
    if (pregs[2] !== 8'h5A || pregs[3] !== 8'h00) begin errors++; $display("FAIL busy_regs: got %h %h expected 5a 00", pregs[2], pregs[3]); end
    checks++;
    if (idle_viol !== v0) begin errors++; $display("FAIL busy_sclk_idle: got %0d expected %0d", idle_viol, v0); end
  endtask

  task automatic test_addr_range();
    int dc, nf, nl, f0, e0;
    logic r1, b1;
    f0 = frames; e0 = err_seen;
    do_write(7'h05, 8'h3C, dc, nf, nl, r1, b1);
    repeat (4) @(negedge clk);
`ifdef SPI_CTRL_ADDR_CHECK_EN
    checks++;
    if (dc !== 1 || nf !== -1) begin errors++; $display("FAIL addr_reject: got done %0d ncs %0d expected 1 -1", dc, nf); end
    checks++;
    if (err_seen - e0 !== 1 || frames !== f0) begin errors++; $display("FAIL addr_err: got %0d frames %0d expected 1 %0d", err_seen - e0, frames, f0); end
    checks++;
    if (r1 !== 1'b1) begin errors++; $display("FAIL addr_ready_c1: got %b expected 1", r1); end
`else
    checks++;
    if (dc !== 141 || nf !== 1) begin errors++; $display("FAIL addr_sent: got done %0d ncs %0d expected 141 1", dc, nf); end
    checks++;
    if (last_frame !== 16'h853C || frames - f0 !== 1) begin errors++; $display("FAIL addr_frame: got %h expected 853c", last_frame); end
    checks++;
    if (err_seen !== e0) begin errors++; $display("FAIL addr_err_zero: got %0d expected %0d", err_seen, e0); end
`endif
    checks++;
    if ({pregs[0], pregs[1], pregs[2], pregs[3], pregs[4]} !== 40'hF0AA5A0055) begin
      errors++; $display("FAIL addr_regs: got %h expected f0aa5a0055", {pregs[0], pregs[1], pregs[2], pregs[3], pregs[4]});
    end
  endtask

  task automatic test_clkdiv6();
    int dc = -1, lowcnt = 0, run = 0, badrun = 0, rb = 0, idle_b = 0;
    logic prev = 1'b0;
    @(negedge clk);
    req_valid_b = 1'b1; req_addr_b = 7'h01; req_data_b = 8'h0F;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_b = 1'b0;
      if (ncs_b === 1'b1 && sclk_b === 1'b1) idle_b++;
      if (ncs_b === 1'b0) begin
        lowcnt++;
        if (sclk_b !== prev) begin
          if (run != 6) badrun++;
          if (sclk_b === 1'b1) rb++;
          run = 1;
        end else begin
          run++;
        end
        prev = sclk_b;
      end
      if (done_b === 1'b1) begin dc = k; break; end
    end
    checks++;
    if (dc !== 207) begin errors++; $display("FAIL div6_done_cycle: got %0d expected 207", dc); end
    checks++;
    if (lowcnt !== 198) begin errors++; $display("FAIL div6_ncs_low: got %0d expected 198", lowcnt); end
    checks++;
    if (badrun !== 0) begin errors++; $display("FAIL div6_phase: got %0d bad phases expected 0", badrun); end
    checks++;
    if (rb !== 16 || idle_b !== 0) begin errors++; $display("FAIL div6_rises: got %0d idle %0d expected 16 0", rb, idle_b); end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) pregs[i] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_valid_while_busy();
    test_addr_range();
    test_clkdiv6();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
